// File: rtl/piso_out_ctrl_if.sv
// Handshake and PISO-control bundle between piso_out_ctrl, the output PISO,
// the external host and the NPU top-level sequencer.
interface piso_out_ctrl_if;
  logic       START;
  logic       ABORT;
  logic       DOUT_READY;
  logic       EN_PISO_OUT;
  logic       SHIFT_OUT;
  logic       CLR_PISO_OUT;
  logic       DOUT_VALID;
  logic       DOUT_LAST;
  logic [3:0] BYTE_IDX;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  START, ABORT, DOUT_READY,
    output EN_PISO_OUT, SHIFT_OUT, CLR_PISO_OUT,
           DOUT_VALID, DOUT_LAST, BYTE_IDX, BUSY, DONE
  );

  modport slave (
    output START, ABORT, DOUT_READY,
    input  EN_PISO_OUT, SHIFT_OUT, CLR_PISO_OUT,
           DOUT_VALID, DOUT_LAST, BYTE_IDX, BUSY, DONE
  );
endinterface

// File: rtl/piso_out_ctrl.sv
// Sequencer for the output PISO: loads the MAC/ReLU results, then paces the
// D_OUT bytes to the host over valid/ready and signals frame completion.
module piso_out_ctrl #(
  parameter int NUM_BYTES   = 4,
  parameter bit CLR_ON_DONE = 1'b1
) (
  input logic             CLKEXT,
  input logic             RST_GLO,
  piso_out_ctrl_if.master bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PRESENT,
    FINISH,
    ABORT_ST
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] byte_cnt, byte_cnt_nxt;
  logic       is_last;

  assign is_last = (byte_cnt == LAST_IDX);

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state    <= IDLE;
      byte_cnt <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  // Outputs depend only on state and byte_cnt, so no input reaches an output combinationally.
  always_comb begin
    state_nxt        = state;
    byte_cnt_nxt     = byte_cnt;
    bus.EN_PISO_OUT  = 1'b0;
    bus.SHIFT_OUT    = 1'b0;
    bus.CLR_PISO_OUT = 1'b0;
    bus.DOUT_VALID   = 1'b0;
    bus.DOUT_LAST    = 1'b0;
    bus.BYTE_IDX     = '0;
    bus.BUSY         = 1'b1;
    bus.DONE         = 1'b0;

    case (state)
      IDLE: begin
        bus.BUSY = 1'b0;
        if (bus.START && !bus.ABORT) begin
          state_nxt    = LOAD;
          byte_cnt_nxt = '0;
        end
      end

      LOAD: begin
        bus.EN_PISO_OUT = 1'b1;
        state_nxt       = bus.ABORT ? ABORT_ST : SHIFT;
      end

      SHIFT: begin
        bus.EN_PISO_OUT = 1'b1;
        bus.SHIFT_OUT   = 1'b1;
        state_nxt       = bus.ABORT ? ABORT_ST : PRESENT;
      end

      PRESENT: begin
        bus.DOUT_VALID = 1'b1;
        bus.DOUT_LAST  = is_last;
        bus.BYTE_IDX   = byte_cnt;
        if (bus.ABORT) begin
          state_nxt = ABORT_ST;
        end else if (bus.DOUT_READY) begin
          if (is_last) begin
            state_nxt = FINISH;
          end else begin
            state_nxt    = SHIFT;
            byte_cnt_nxt = byte_cnt + 4'd1;
          end
        end
      end

      FINISH: begin
        bus.DONE         = 1'b1;
        bus.CLR_PISO_OUT = CLR_ON_DONE;
        state_nxt        = IDLE;
      end

      ABORT_ST: begin
        bus.CLR_PISO_OUT = 1'b1;
        state_nxt        = IDLE;
      end

      default: begin
        bus.BUSY  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_out_ctrl.sv
// Directed bench for piso_out_ctrl: a 4-byte/clear-on-done instance and a
// 2-byte/no-clear instance, each feeding a behavioural PISO.
module tb_piso_out_ctrl;

  logic CLKEXT = 1'b0;
  logic RST_GLO;

  always #5 CLKEXT = ~CLKEXT;

  piso_out_ctrl_if ifA ();
  piso_out_ctrl_if ifB ();

  piso_out_ctrl #(.NUM_BYTES(4), .CLR_ON_DONE(1'b1)) dutA (
    .CLKEXT (CLKEXT),
    .RST_GLO(RST_GLO),
    .bus    (ifA)
  );

  piso_out_ctrl #(.NUM_BYTES(2), .CLR_ON_DONE(1'b0)) dutB (
    .CLKEXT (CLKEXT),
    .RST_GLO(RST_GLO),
    .bus    (ifB)
  );

  logic [15:0] mac0, mac1;
  logic [31:0] pisoA, pisoB;
  logic [7:0]  doutA, doutB;

  // Behavioural PISOs: load {mac1, mac0}, shift out most significant byte first.
  always @(posedge CLKEXT) begin
    if (RST_GLO || ifA.CLR_PISO_OUT) begin
      pisoA <= '0;
      doutA <= '0;
    end else if (ifA.EN_PISO_OUT) begin
      if (!ifA.SHIFT_OUT) pisoA <= {mac1, mac0};
      else begin
        doutA <= pisoA[31:24];
        pisoA <= {pisoA[23:0], 8'h00};
      end
    end
  end

  always @(posedge CLKEXT) begin
    if (RST_GLO || ifB.CLR_PISO_OUT) begin
      pisoB <= '0;
      doutB <= '0;
    end else if (ifB.EN_PISO_OUT) begin
      if (!ifB.SHIFT_OUT) pisoB <= {mac1, mac0};
      else begin
        doutB <= pisoB[31:24];
        pisoB <= {pisoB[23:0], 8'h00};
      end
    end
  end

  int numCompared   = 0;
  int numMismatched = 0;

  logic [7:0] capByte [16];
  logic       capLast [16];
  logic [3:0] capIdx  [16];
  int capCount, firstValid, doneCount, doneCyc, clrCount, clrCyc, endCyc;
  int stallEn, stallChanged;
  logic loadOk, shiftOk;
  logic [7:0] expB [4];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic ready);
    ifA.START      = start;
    ifA.ABORT      = abort;
    ifA.DOUT_READY = ready;
    ifB.START      = start;
    ifB.ABORT      = abort;
    ifB.DOUT_READY = ready;
  endtask

  task automatic step();
    @(negedge CLKEXT);
  endtask

  function automatic logic [10:0] packOut(input bit sel);
    if (sel)
      return {ifB.EN_PISO_OUT, ifB.SHIFT_OUT, ifB.CLR_PISO_OUT, ifB.DOUT_VALID,
              ifB.DOUT_LAST, ifB.BYTE_IDX, ifB.BUSY, ifB.DONE};
    return {ifA.EN_PISO_OUT, ifA.SHIFT_OUT, ifA.CLR_PISO_OUT, ifA.DOUT_VALID,
            ifA.DOUT_LAST, ifA.BYTE_IDX, ifA.BUSY, ifA.DONE};
  endfunction

  // Pulses START in cycle 0 and observes cycle k after the k-th negedge.
  task automatic runFrame(input bit sel, input int stallIdx, input int stallLen,
                          input int abortIdx, input int startIdx, input bit abortAtDone);
    int stallCnt;
    bit startSent;
    logic [7:0] stallByte, dout;
    logic valid, last, en, sh, clr, busy, done, st, ab, rdy;
    logic [3:0] idx;
    stallCnt = 0; startSent = 0; stallByte = '0;
    capCount = 0; firstValid = -1; doneCount = 0; doneCyc = -1;
    clrCount = 0; clrCyc = -1; endCyc = -1; stallEn = 0; stallChanged = 0;
    loadOk = 1'b0; shiftOk = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      step();
      if (sel) begin
        valid = ifB.DOUT_VALID; last = ifB.DOUT_LAST; idx = ifB.BYTE_IDX;
        en = ifB.EN_PISO_OUT; sh = ifB.SHIFT_OUT; clr = ifB.CLR_PISO_OUT;
        busy = ifB.BUSY; done = ifB.DONE; dout = doutB;
      end else begin
        valid = ifA.DOUT_VALID; last = ifA.DOUT_LAST; idx = ifA.BYTE_IDX;
        en = ifA.EN_PISO_OUT; sh = ifA.SHIFT_OUT; clr = ifA.CLR_PISO_OUT;
        busy = ifA.BUSY; done = ifA.DONE; dout = doutA;
      end
      st = 1'b0; ab = 1'b0; rdy = 1'b1;
      if (k == 1) loadOk = en && !sh && busy;
      if (k == 2) shiftOk = en && sh;
      if (valid) begin
        if (firstValid < 0) firstValid = k;
        if (int'(idx) == abortIdx) ab = 1'b1;
        else if (int'(idx) == stallIdx && stallCnt < stallLen) begin
          if (stallCnt == 0) stallByte = dout;
          else if (dout !== stallByte) stallChanged++;
          if (en || sh) stallEn++;
          stallCnt++;
          rdy = 1'b0;
        end
        if (int'(idx) == startIdx && !startSent) begin
          st = 1'b1;
          startSent = 1;
        end
        if (rdy && !ab && capCount < 16) begin
          capByte[capCount] = dout;
          capLast[capCount] = last;
          capIdx[capCount]  = idx;
          capCount++;
        end
      end
      if (done) begin
        doneCount++;
        doneCyc = k;
        if (abortAtDone) ab = 1'b1;
      end
      if (clr) begin
        clrCount++;
        clrCyc = k;
      end
      applyStimulus(st, ab, rdy);
      if (!busy) begin
        endCyc = k;
        break;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("frame_terminates", 32'(endCyc > 0), 32'd1);
  endtask

  task automatic checkBytes(input string tag, input int n);
    checkOutput({tag, "_count"}, capCount, n);
    for (int i = 0; i < n && i < capCount; i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(capByte[i]), 32'(expB[i]));
      checkOutput($sformatf("%s_idx%0d", tag, i), 32'(capIdx[i]), i);
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(capLast[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int doneSeen;
    RST_GLO = 1'b1;
    mac0 = 16'h1234;
    mac1 = 16'hABCD;
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("reset_outputs_A", 32'(packOut(1'b0)), 32'd0);
    checkOutput("reset_outputs_B", 32'(packOut(1'b1)), 32'd0);
    RST_GLO = 1'b0;
    step();

    // Basic frame
    runFrame(1'b0, -1, 0, -1, -1, 1'b0);
    expB = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    checkOutput("basic_load", 32'(loadOk), 32'd1);
    checkOutput("basic_shift", 32'(shiftOk), 32'd1);
    checkOutput("basic_first_valid", firstValid, 3);
    checkBytes("basic", 4);
    checkOutput("basic_done_count", doneCount, 1);
    checkOutput("basic_done_cycle", doneCyc, 10);
    checkOutput("basic_clr_cycle", clrCyc, 10);
    checkOutput("basic_clr_count", clrCount, 1);
    checkOutput("basic_idle_cycle", endCyc, 11);

    // Backpressure on byte 1
    step();
    runFrame(1'b0, 1, 5, -1, -1, 1'b0);
    checkOutput("stall_first_valid", firstValid, 3);
    checkBytes("stall", 4);
    checkOutput("stall_en_pulses", stallEn, 0);
    checkOutput("stall_dout_changed", stallChanged, 0);
    checkOutput("stall_hold_byte", 32'(capByte[1]), 32'h0000_00CD);
    checkOutput("stall_done_cycle", doneCyc, 15);

    // Abort during PRESENT of byte 2, then a fresh frame
    step();
    runFrame(1'b0, -1, 0, 2, -1, 1'b0);
    checkOutput("abort_bytes", capCount, 2);
    checkOutput("abort_done_count", doneCount, 0);
    checkOutput("abort_clr_cycle", clrCyc, 8);
    checkOutput("abort_clr_count", clrCount, 1);
    checkOutput("abort_idle_cycle", endCyc, 9);
    mac0 = 16'h00FF;
    mac1 = 16'h8001;
    step();
    runFrame(1'b0, -1, 0, -1, -1, 1'b0);
    expB = '{8'h80, 8'h01, 8'h00, 8'hFF};
    checkBytes("post_abort", 4);
    checkOutput("post_abort_done_cycle", doneCyc, 10);

    // START while busy, ABORT during FINISH
    mac0 = 16'h1234;
    mac1 = 16'hABCD;
    step();
    runFrame(1'b0, -1, 0, -1, 1, 1'b1);
    checkOutput("collide_done_count", doneCount, 1);
    checkOutput("collide_done_cycle", doneCyc, 10);
    checkOutput("collide_clr_count", clrCount, 1);
    checkOutput("collide_idle_cycle", endCyc, 11);
    step();
    step();
    checkOutput("collide_no_restart", 32'(ifA.BUSY), 32'd0);

    // START and ABORT together in IDLE, then ABORT alone
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    checkOutput("start_abort_en", 32'(ifA.EN_PISO_OUT), 32'd0);
    checkOutput("start_abort_busy", 32'(ifA.BUSY), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    checkOutput("idle_abort_outputs", 32'(packOut(1'b0)), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();

    // Reset during SHIFT of byte 1
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    checkOutput("rst_pre_shift", 32'({ifA.EN_PISO_OUT, ifA.SHIFT_OUT}), 32'd3);
    RST_GLO = 1'b1;
    step();
    checkOutput("rst_mid_outputs", 32'(packOut(1'b0)), 32'd0);
    RST_GLO = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ifA.DONE || ifA.BUSY) doneSeen++;
    end
    checkOutput("rst_no_done", doneSeen, 0);
    runFrame(1'b0, -1, 0, -1, -1, 1'b0);
    expB = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    checkBytes("post_rst", 4);
    checkOutput("post_rst_done_cycle", doneCyc, 10);

    // Two-byte instance without clear-on-done
    step();
    runFrame(1'b1, -1, 0, -1, -1, 1'b0);
    expB = '{8'hAB, 8'hCD, 8'h00, 8'h00};
    checkBytes("nb2", 2);
    checkOutput("nb2_done_count", doneCount, 1);
    checkOutput("nb2_done_cycle", doneCyc, 6);
    checkOutput("nb2_clr_count", clrCount, 0);
    checkOutput("nb2_idle_cycle", endCyc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/piso_out_ctrl.md
Name: piso_out_ctrl

Overview:
Sequencer directly upstream of the output PISO. It drives EN_PISO_OUT, SHIFT_OUT and CLR_PISO_OUT so the PISO loads the two 16-bit MAC/ReLU results. It then paces the four resulting D_OUT bytes to the external host with a valid/ready handshake, and reports completion to the NPU top-level sequencer.

Parameters:
NUM_BYTES, 4, bytes shifted per result frame (2..15); 4 matches the PISO depth.
CLR_ON_DONE, 1, 1 = pulse CLR_PISO_OUT for one cycle when a frame completes; 0 = no clear.

Ports:
CLKEXT  in  1  system clock; all logic on rising edge.
RST_GLO  in  1  reset, synchronous, active-high.
START  in  1  one-cycle request: MAC results are stable and may be loaded.
ABORT  in  1  cancel the frame in progress.
DOUT_READY  in  1  host accepts the byte currently on D_OUT.
EN_PISO_OUT  out  1  PISO enable.
SHIFT_OUT  out  1  PISO mode: 0 = load, 1 = shift.
CLR_PISO_OUT  out  1  PISO synchronous clear.
DOUT_VALID  out  1  D_OUT holds a valid byte.
DOUT_LAST  out  1  qualifies DOUT_VALID: final byte of the frame.
BYTE_IDX  out  4  index of the byte presented, 0 = first.
BUSY  out  1  frame in progress (state != IDLE).
DONE  out  1  one-cycle pulse: frame completed normally.

Behaviour:
- One clock (CLKEXT); reset is synchronous and active-high (RST_GLO).
- Reset: state = IDLE, byte counter = 0, every output = 0. Reset mid-frame drops the frame with no DONE and no CLR pulse; the PISO is reset by the same RST_GLO.
- All outputs decode from registered state and counter only; there is no combinational input-to-output path.
- IDLE: all outputs 0. START=1 -> LOAD, counter := 0.
- LOAD, 1 cycle: EN_PISO_OUT=1, SHIFT_OUT=0. -> SHIFT.
- SHIFT, 1 cycle: EN_PISO_OUT=1, SHIFT_OUT=1. The PISO updates D_OUT at the end of this cycle. -> PRESENT.
- PRESENT: DOUT_VALID=1, EN_PISO_OUT=0, BYTE_IDX = counter, DOUT_LAST = (counter == NUM_BYTES-1). Stay while DOUT_READY=0; D_OUT stays stable because the PISO is not enabled.
  - DOUT_READY=1 and not last: counter++ and go to SHIFT.
  - DOUT_READY=1 and last: go to FINISH.
- FINISH, 1 cycle: DONE=1; CLR_PISO_OUT=CLR_ON_DONE. -> IDLE.
- ABORT_ST, 1 cycle: CLR_PISO_OUT=1, DONE=0. -> IDLE.
- Latency: START sampled at edge N gives first DOUT_VALID during cycle N+3. With READY held high, steady state is one byte per 2 cycles, so a frame takes 2*NUM_BYTES+2 cycles from START to DONE.
- Byte order on D_OUT for NUM_BYTES=4: mac1[15:8], mac1[7:0], mac0[15:8], mac0[7:0].
- Boundary conditions:
  - START while BUSY: ignored, not queued.
  - ABORT=1 in LOAD, SHIFT or PRESENT: go to ABORT_ST next cycle, overriding READY.
  - ABORT in FINISH: ignored, DONE still pulses.
  - ABORT in IDLE: ignored.
  - START and ABORT together in IDLE: ABORT wins and START is dropped.
  - DOUT_READY outside PRESENT: ignored.
  - Counter never wraps within a frame; it clears on START.
- BUSY=1 in LOAD, SHIFT, PRESENT, FINISH and ABORT_ST.

Test Plan:
- Basic frame: mac0=0x1234, mac1=0xABCD, START pulse, READY held 1 -> D_OUT bytes 0xAB,0xCD,0x12,0x34 with BYTE_IDX 0..3. DOUT_LAST only on 0x34. First VALID 3 cycles after START; DONE 10 cycles after START; CLR_PISO_OUT pulses with DONE; BUSY low afterwards.
- Backpressure: READY low for 5 cycles on byte 1, then high -> DOUT_VALID held, D_OUT stays 0xCD, no SHIFT_OUT pulse during the stall, remaining order unchanged, DONE 5 cycles later than in the basic frame.
- Abort: ABORT during PRESENT of byte 2 -> next cycle CLR_PISO_OUT=1, DONE never asserts, IDLE after 1 cycle; a following START with mac0=0x00FF, mac1=0x8001 delivers 0x80,0x01,0x00,0xFF.
- Collisions: START pulsed during PRESENT -> ignored, single DONE. START+ABORT together in IDLE -> stays IDLE, no EN_PISO_OUT.
- Reset mid-frame: RST_GLO during SHIFT of byte 1 -> next cycle every output 0, no DONE. A new frame completes normally.
- Parameters: NUM_BYTES=2, CLR_ON_DONE=0 -> only 0xAB,0xCD presented, DOUT_LAST on 0xCD, DONE with no CLR_PISO_OUT pulse.
